display_scan: RTL and testbench

//  Multiplexed digit scanner for the 8-digit 7-segment board. It latches a 32-bit result word and

---
 rtl/display_scan_if.sv | 21 ++
 rtl/display_scan.sv | 119 +++++++++++
 tb/tb_display_scan.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/display_scan_if.sv
// rtl/display_scan_if.sv - producer/decoder-side signal bundle for display_scan
interface display_scan_if #(
    parameter int NDIG = 8
);
    logic                load;
    logic [4*NDIG-1:0]   data;
    logic                busy;
    logic [4:0]          code;
    logic [NDIG-1:0]     an;
    logic                shown;

    modport master (
        output load, data, busy,
        input  code, an, shown
    );

    modport slave (
        input  load, data, busy,
        output code, an, shown
    );
endinterface

// File: rtl/display_scan.sv
// rtl/display_scan.sv - multiplexed 7-segment digit scanner (symbol code + active-low anode)
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module display_scan #(
    parameter int NDIG     = 8,
    parameter int PRESCALE = 50000,
    parameter int PS_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    display_scan_if.slave    bus
);
    localparam int              IDX_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);

    localparam logic [4:0] SYM_DASH  = 5'd16;
    localparam logic [4:0] SYM_BLANK = 5'd31;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        WAIT  = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PS_W-1:0]     ps;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_nxt;
    logic [4*NDIG-1:0]   dreg;
    logic                have;
    logic                tick;
    logic [3:0]          nib;
    logic [4:0]          sym_nxt;

    assign tick    = (ps == PS_LAST);
    assign idx_nxt = (idx == LAST_IDX) ? '0 : idx + 1'b1;

    // busy always wins; a load in the same cycle still lands in dreg
    always_comb begin
        state_nxt = state;
        case (state)
            BLANK: begin
                if (bus.busy)      state_nxt = WAIT;
                else if (bus.load) state_nxt = SHOW;
            end
            WAIT: begin
                if (!bus.busy) state_nxt = (have || bus.load) ? SHOW : BLANK;
            end
            SHOW: begin
                if (bus.busy) state_nxt = WAIT;
            end
            default: state_nxt = BLANK;
        endcase
    end

    always_comb begin
        nib = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_nxt == IDX_W'(i)) nib = dreg[4*i +: 4];
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd;

    // highest nonzero nibble; stays 0 for an all-zero word so digit 0 still lights
    always_comb begin
        msd = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (dreg[4*i +: 4] != 4'h0) msd = IDX_W'(i);
        end
    end
`endif

    always_comb begin
        sym_nxt = SYM_BLANK;
        case (state)
            WAIT: sym_nxt = SYM_DASH;
            SHOW: begin
                sym_nxt = {1'b0, nib};
`ifdef LEADING_ZERO_BLANK_EN
                if (idx_nxt > msd) sym_nxt = SYM_BLANK;
`endif
            end
            default: sym_nxt = SYM_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps        <= '0;
            idx       <= LAST_IDX;
            state     <= BLANK;
            dreg      <= '0;
            have      <= 1'b0;
            bus.code  <= SYM_BLANK;
            bus.an    <= '1;
            bus.shown <= 1'b0;
        end else begin
            ps <= tick ? '0 : ps + 1'b1;

            // code and anode move together so the decoder never sees a mixed pair
            if (tick) begin
                idx      <= idx_nxt;
                bus.an   <= ~(NDIG'(1) << idx_nxt);
                bus.code <= sym_nxt;
            end

            if (bus.load) begin
                dreg <= bus.data;
                have <= 1'b1;
            end

            state     <= state_nxt;
            bus.shown <= (state_nxt == SHOW);
        end
    end
endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - randomized self-checking bench for display_scan against a cycle-count reference
module tb_display_scan;
    localparam int NDIG     = 8;
    localparam int PRESCALE = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    display_scan_if #(.NDIG(NDIG)) bus ();

    display_scan #(
        .NDIG     (NDIG),
        .PRESCALE (PRESCALE),
        .PS_W     (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: 0=blank 1=wait(dashes) 2=show
    int          m_cyc;
    int          m_st;
    bit          m_have;
    logic [31:0] m_d;
    logic [31:0] exp_code;
    logic [31:0] exp_an;
    logic [31:0] exp_shown;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sym_ref(input int st, input logic [31:0] d, input int dig);
        logic [31:0] upper;
        upper = d >> (4 * dig);
        if (st == 0) return 32'd31;
        if (st == 1) return 32'd16;
`ifdef LEADING_ZERO_BLANK_EN
        if (dig > 0 && upper == 32'd0) return 32'd31;
`endif
        return upper & 32'hF;
    endfunction

    function automatic void model_reset();
        m_cyc     = 0;
        m_st      = 0;
        m_have    = 0;
        m_d       = '0;
        exp_code  = 32'd31;
        exp_an    = 32'hFF;
        exp_shown = 32'd0;
    endfunction

    function automatic void model_edge(input bit ld, input logic [31:0] dt, input bit bz);
        int dig;
        if (m_cyc % PRESCALE == PRESCALE - 1) begin
            dig      = (m_cyc / PRESCALE) % NDIG;
            exp_an   = 32'hFF ^ (32'd1 << dig);
            exp_code = sym_ref(m_st, m_d, dig);
        end
        if (bz)                m_st = 1;
        else if (m_st == 0)    m_st = ld ? 2 : 0;
        else if (m_st == 1)    m_st = (m_have || ld) ? 2 : 0;
        if (ld) begin
            m_d    = dt;
            m_have = 1;
        end
        exp_shown = (m_st == 2) ? 32'd1 : 32'd0;
        m_cyc++;
    endfunction

    task automatic step(input bit ld, input logic [31:0] dt, input bit bz);
        bus.load = ld;
        bus.data = dt;
        bus.busy = bz;
        @(posedge clk);
        model_edge(ld, dt, bz);
        #1;
        check("code",  32'(bus.code),  exp_code);
        check("an",    32'(bus.an),    exp_an);
        check("shown", 32'(bus.shown), exp_shown);
        bus.load = 1'b0;
    endtask

    task automatic idle(input int n, input bit bz);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, bz);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_code",  32'(bus.code),  32'd31);
        check("rst_an",    32'(bus.an),    32'hFF);
        check("rst_shown", 32'(bus.shown), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b1;
        bus.load = 1'b0;
        bus.data = '0;
        bus.busy = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        check("rst_code",  32'(bus.code),  32'd31);
        check("rst_an",    32'(bus.an),    32'hFF);
        check("rst_shown", 32'(bus.shown), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        idle(4, 1'b0);
        check("first_an",   32'(bus.an),   32'hFE);
        check("first_code", 32'(bus.code), 32'd31);
        idle(36, 1'b0);

        step(1'b1, 32'h89AB_CDEF, 1'b0);
        check("load_shown", 32'(bus.shown), 32'd1);
        idle(40, 1'b0);

        idle(40, 1'b1);
        idle(40, 1'b0);

        step(1'b1, 32'h1234_5678, 1'b1);
        check("busy_load_shown", 32'(bus.shown), 32'd0);
        idle(40, 1'b1);
        idle(40, 1'b0);

        idle(6, 1'b0);
        do_reset();
        idle(40, 1'b0);

        step(1'b1, 32'h0000_00A0, 1'b0);
        idle(40, 1'b0);
        step(1'b1, 32'h0000_0000, 1'b0);
        idle(40, 1'b0);

        step(1'b1, 32'h0000_0300, 1'b1);
        step(1'b1, 32'h0000_0050, 1'b0);
        idle(40, 1'b0);

        begin
            bit          bz;
            bit          ld;
            logic [31:0] dt;
            bz = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 39) == 0) bz = ~bz;
                ld = ($urandom_range(0, 29) == 0);
                dt = $urandom >> (4 * $urandom_range(0, 8));
                if ($urandom_range(0, 599) == 0) do_reset();
                else step(ld, dt, bz);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
